// File: rtl/neuron_accumulator.sv
// neuron_accumulator: sums the partial sums of one output neuron, adds a bias,
// saturates to 16 bits, applies the activation and offers the result on a
// valid/ready handshake.
module neuron_accumulator #(
   parameter int unsigned MAX_CHUNKS = 255,
   parameter int unsigned ACT_MODE   = 0,
   parameter int unsigned ACC_W      = 25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  num_chunks,
   input  logic [15:0] bias,
   input  logic [15:0] partial_in,
   input  logic        partial_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic [15:0] neuron_out,
   output logic        neuron_valid,
   output logic        sat
);

   localparam int unsigned DATA_W    = 16;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned MIN_ACC_W = 17 + $clog2(MAX_CHUNKS + 1);
   localparam int unsigned HI_W      = ACC_W - DATA_W + 1;

   // Reject accumulator widths that could wrap on a full-length neuron
   if (ACC_W < MIN_ACC_W) begin : g_bad_acc_w
      $error("neuron_accumulator: ACC_W too small for MAX_CHUNKS");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      ACT   = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   out_q, out_d;
   logic                valid_q, valid_d;
   logic                sat_q, sat_d;
   logic                busy_q, busy_d;

   logic [HI_W-1:0]     acc_hi;
   logic                clip;
   logic [DATA_W-1:0]   sat_val;
   logic [DATA_W-1:0]   act_val;

   // Saturate: the value fits in 16 bits only if the bits above bit 14 are all equal
   always_comb begin
      acc_hi  = acc_q[ACC_W-1:DATA_W-1];
      clip    = !((&acc_hi) || !(|acc_hi));
      sat_val = acc_q[DATA_W-1:0];
      if (clip) begin
         sat_val = acc_q[ACC_W-1] ? 16'h8000 : 16'h7FFF;
      end
      if (ACT_MODE == 0) begin
         act_val = sat_val[DATA_W-1] ? 16'h0000 : sat_val;
      end else begin
         act_val = sat_val[DATA_W-1] ? 16'hFFFF : 16'h0001;
      end
   end

   // Next-state and datapath update for the IDLE/ACCUM/ACT/OUT sequence
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      valid_d = valid_q;
      sat_d   = sat_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
               cnt_d   = num_chunks;
               state_d = (num_chunks != 8'd0) ? ACCUM : ACT;
            end
         end
         ACCUM: begin
            if (partial_valid) begin
               acc_d = acc_q + {{(ACC_W-DATA_W){partial_in[DATA_W-1]}}, partial_in};
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  state_d = ACT;
               end
            end
         end
         ACT: begin
            out_d   = act_val;
            sat_d   = clip;
            valid_d = 1'b1;
            state_d = OUT;
         end
         OUT: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         sat_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         sat_q   <= sat_d;
         busy_q  <= busy_d;
      end
   end

   assign busy         = busy_q;
   assign neuron_out   = out_q;
   assign neuron_valid = valid_q;
   assign sat          = sat_q;

endmodule
